// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state encodings and constants for the AHB ADC read slave
package adc_pkg;

  typedef enum logic [1:0] {
    A_IDLE,
    A_START,
    A_BUSY,
    A_DONE
  } bus_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV,
    S_SETUP,
    S_SHIFT,
    S_QUIET
  } ser_state_t;

  // Values of HADDR[2] selecting the two register offsets
  localparam logic ADDR_CONVERT = 1'b0;
  localparam logic ADDR_LAST    = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_adc_read_if.sv
// rtl/ahb_adc_read_if.sv - AHB-Lite slave-side signal bundle for the ADC read slave
interface ahb_adc_read_if;

  logic        HSEL;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HWRITE, HREADY, HADDR, HWDATA, HTRANS, HSIZE, HPROT, HBURST, HMASTLOCK,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HWRITE, HREADY, HADDR, HWDATA, HTRANS, HSIZE, HPROT, HBURST, HMASTLOCK,
    input  HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/adc_serial_read.sv
// rtl/adc_serial_read.sv - serial ADC frame sequencer: CNVST pulse, CSn framing, SCLK and shift-in
module adc_serial_read
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int NBITS   = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  output logic             ready,
  output logic [NBITS-1:0] data,
  output logic             ADC_CNVST,
  output logic             ADC_CSn,
  output logic             ADC_SCLK,
  input  logic             ADC_DOUT
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(NBITS);
  localparam logic [CW-1:0] HALF     = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] QUIET    = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  ser_state_t       state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [BW-1:0]    bit_cnt, bit_next;
  logic             cnvst_next, csn_next, sclk_next, shift_en;
  logic             dout_meta, dout_sync;
  logic [NBITS-1:0] shreg;

  assign ready = (state == S_IDLE);
  assign data  = shreg;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_cnt;
    cnvst_next = 1'b0;
    csn_next   = 1'b1;
    sclk_next  = 1'b0;
    shift_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_CNV;
          cnt_next   = HALF;
          cnvst_next = 1'b1;
        end
      end
      S_CNV: begin
        if (cnt == '0) begin
          state_next = S_SETUP;
          cnt_next   = HALF;
          csn_next   = 1'b0;
        end else begin
          cnt_next   = cnt - 1'b1;
          cnvst_next = 1'b1;
        end
      end
      S_SETUP: begin
        csn_next = 1'b0;
        if (cnt == '0) begin
          state_next = S_SHIFT;
          cnt_next   = HALF;
          bit_next   = '0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_SHIFT: begin
        csn_next  = 1'b0;
        sclk_next = ADC_SCLK;
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (!ADC_SCLK) begin
          // Rising SCLK edge: sample the synchronised data bit
          cnt_next  = HALF;
          sclk_next = 1'b1;
          shift_en  = 1'b1;
        end else if (bit_cnt == LAST_BIT) begin
          state_next = S_QUIET;
          cnt_next   = QUIET;
          sclk_next  = 1'b0;
          csn_next   = 1'b1;
        end else begin
          cnt_next  = HALF;
          sclk_next = 1'b0;
          bit_next  = bit_cnt + 1'b1;
        end
      end
      S_QUIET: begin
        if (cnt == '0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      ADC_CNVST <= 1'b0;
      ADC_CSn   <= 1'b1;
      ADC_SCLK  <= 1'b0;
      dout_meta <= 1'b0;
      dout_sync <= 1'b0;
      shreg     <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_cnt   <= bit_next;
      ADC_CNVST <= cnvst_next;
      ADC_CSn   <= csn_next;
      ADC_SCLK  <= sclk_next;
      dout_meta <= ADC_DOUT;
      dout_sync <= dout_meta;
      if (shift_en) begin
        shreg <= {shreg[NBITS-2:0], dout_sync};
      end
    end
  end

endmodule

// File: rtl/ahb_adc_read.sv
// rtl/ahb_adc_read.sv - AHB-Lite slave that runs one ADC conversion per read and returns {chB, chA}
module ahb_adc_read
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int NBITS   = 32
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahb_adc_read_if.slave  bus,
  output logic           ADC_CNVST,
  output logic           ADC_CSn,
  output logic           ADC_SCLK,
  input  logic           ADC_DOUT
);

  bus_state_t       state, state_next;
  logic             accept;
  logic             wr_q;
  logic             saw_fall;
  logic             start;
  logic             ready;
  logic             capture;
  logic             load_rdata;
  logic             hreadyout_q, hreadyout_next;
  logic [31:0]      hrdata_q;
  logic [NBITS-1:0] data;
  logic [NBITS-1:0] last_sample;
  logic             unused_bus;

  assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] && (bus.HSIZE == HSIZE_WORD);

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.HRESP     = 2'b00;

  assign unused_bus = ^{bus.HADDR[31:3], bus.HADDR[1:0], bus.HWDATA, bus.HTRANS[0],
                        bus.HPROT, bus.HBURST, bus.HMASTLOCK};

  always_comb begin
    state_next     = state;
    hreadyout_next = hreadyout_q;
    start          = 1'b0;
    capture        = 1'b0;
    load_rdata     = 1'b0;
    case (state)
      A_IDLE: begin
        if (accept) begin
          hreadyout_next = 1'b0;
          if (bus.HWRITE || (bus.HADDR[2] != ADDR_CONVERT)) begin
            state_next = A_DONE;
          end else begin
            state_next = A_START;
          end
        end
      end
      A_START: begin
        start      = 1'b1;
        state_next = A_BUSY;
      end
      A_BUSY: begin
        // ready returning high after having dropped marks the finished frame
        if (saw_fall && ready) begin
          capture    = 1'b1;
          state_next = A_DONE;
        end
      end
      A_DONE: begin
        load_rdata     = !wr_q;
        hreadyout_next = 1'b1;
        state_next     = A_IDLE;
      end
      default: state_next = A_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= A_IDLE;
      wr_q        <= 1'b0;
      saw_fall    <= 1'b0;
      last_sample <= '0;
      hreadyout_q <= 1'b1;
      hrdata_q    <= '0;
    end else begin
      state       <= state_next;
      hreadyout_q <= hreadyout_next;
      saw_fall    <= (state == A_BUSY) && (saw_fall || !ready);
      if (state == A_IDLE && accept) begin
        wr_q <= bus.HWRITE;
      end
      if (capture) begin
        last_sample <= data;
      end
      if (load_rdata) begin
        hrdata_q <= 32'(last_sample);
      end
    end
  end

  adc_serial_read #(
    .CLK_DIV (CLK_DIV),
    .NBITS   (NBITS)
  ) u_serial (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .ready     (ready),
    .data      (data),
    .ADC_CNVST (ADC_CNVST),
    .ADC_CSn   (ADC_CSn),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_DOUT  (ADC_DOUT)
  );

endmodule

// File: tb/tb_ahb_adc_read.sv
// tb/tb_ahb_adc_read.sv - bench for ahb_adc_read with a serial ADC model and scoreboard
module tb_ahb_adc_read;

  localparam int CD          = 2;
  localparam int CONV_WAITS  = 68 * CD + 3;
  localparam int FRAME_BITS  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cnvst, csn, sclk;
  logic dout = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Pin activity totals and the ADC model's frame
  int cnvst_hi  = 0;
  int csn_lo    = 0;
  int sclk_hi   = 0;
  int sclk_rise = 0;
  int bit_idx   = 0;
  logic prev_csn  = 1'b1;
  logic prev_sclk = 1'b0;
  logic [31:0] adc_frame = 32'h0;

  logic [31:0] exp_last  = 32'h0;
  logic [31:0] exp_rdata = 32'h0;

  ahb_adc_read_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_adc_read #(
    .CLK_DIV (CD),
    .NBITS   (FRAME_BITS)
  ) dut (
    .HCLK      (clk),
    .HRESET    (rst),
    .bus       (bus.slave),
    .ADC_CNVST (cnvst),
    .ADC_CSn   (csn),
    .ADC_SCLK  (sclk),
    .ADC_DOUT  (dout)
  );

  always #5 clk = ~clk;

  // ADC model: MSB on CSn fall, next bit after each SCLK rise
  always @(negedge clk) begin
    if (cnvst === 1'b1) cnvst_hi = cnvst_hi + 1;
    if (csn === 1'b0) csn_lo = csn_lo + 1;
    if (sclk === 1'b1) sclk_hi = sclk_hi + 1;
    if (prev_csn === 1'b1 && csn === 1'b0) begin
      bit_idx = 0;
      dout    = adc_frame[31];
    end
    if (prev_sclk === 1'b0 && sclk === 1'b1) begin
      sclk_rise = sclk_rise + 1;
      bit_idx   = bit_idx + 1;
      if (bit_idx < FRAME_BITS) dout = adc_frame[31 - bit_idx];
    end
    prev_csn  = csn;
    prev_sclk = sclk;
  end

  task automatic do_xfer(input logic wr, input logic a2, input logic [2:0] size,
                         input logic [1:0] trans, input logic [31:0] wdata,
                         output int waits, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    bus.HSEL   = 1'b1;
    bus.HWRITE = wr;
    bus.HADDR  = {29'd0, a2, 2'b00};
    bus.HSIZE  = size;
    bus.HTRANS = trans;
    @(posedge clk);
    #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = wdata;
    n = 0;
    @(negedge clk);
    while (bus.HREADYOUT !== 1'b1 && n < 1000) begin
      n = n + 1;
      @(negedge clk);
    end
    waits = (n >= 1000) ? -1 : n;
    rdata = bus.HRDATA;
  endtask

  task automatic test_reset();
    int c0, l0, r0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    c0 = cnvst_hi; l0 = csn_lo; r0 = sclk_rise;
    repeat (10) @(posedge clk);
    #1;
    checks = checks + 1;
    if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0 || bus.HRESP !== 2'b00) begin
      failures = failures + 1;
      $display("FAIL reset_bus: hreadyout=%b hrdata=%h hresp=%b required 1/00000000/00",
               bus.HREADYOUT, bus.HRDATA, bus.HRESP);
    end
    checks = checks + 1;
    if (csn !== 1'b1 || sclk !== 1'b0 || cnvst !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_pins: csn=%b sclk=%b cnvst=%b required 1/0/0", csn, sclk, cnvst);
    end
    checks = checks + 1;
    if (cnvst_hi != c0 || csn_lo != l0 || sclk_rise != r0) begin
      failures = failures + 1;
      $display("FAIL reset_idle_activity: cnvst=%0d csn=%0d sclk=%0d required none",
               cnvst_hi - c0, csn_lo - l0, sclk_rise - r0);
    end
  endtask

  task automatic convert_and_check(input string name, input logic [31:0] frame);
    int c0, l0, h0, r0, w;
    logic [31:0] rd;
    adc_frame = frame;
    c0 = cnvst_hi; l0 = csn_lo; h0 = sclk_hi; r0 = sclk_rise;
    do_xfer(1'b0, 1'b0, 3'b010, 2'b10, 32'h0, w, rd);
    exp_last  = frame;
    exp_rdata = frame;
    checks = checks + 1;
    if (w != CONV_WAITS) begin
      failures = failures + 1;
      $display("FAIL %s_waits: got %0d required %0d", name, w, CONV_WAITS);
    end
    checks = checks + 1;
    if (rd !== exp_rdata) begin
      failures = failures + 1;
      $display("FAIL %s_data: got %h required %h", name, rd, exp_rdata);
    end
    checks = checks + 1;
    if (cnvst_hi - c0 != CD || sclk_rise - r0 != FRAME_BITS ||
        sclk_hi - h0 != FRAME_BITS * CD || csn_lo - l0 != (FRAME_BITS * 2 + 1) * CD) begin
      failures = failures + 1;
      $display("FAIL %s_pins: cnvst=%0d rises=%0d sclk_hi=%0d csn_lo=%0d required %0d/%0d/%0d/%0d",
               name, cnvst_hi - c0, sclk_rise - r0, sclk_hi - h0, csn_lo - l0,
               CD, FRAME_BITS, FRAME_BITS * CD, (FRAME_BITS * 2 + 1) * CD);
    end
  endtask

  task automatic short_xfer_check(input string name, input logic wr, input logic a2,
                                  input logic [2:0] size, input logic [1:0] trans,
                                  input logic [31:0] wdata, input int exp_waits);
    int c0, l0, w;
    logic [31:0] rd;
    c0 = cnvst_hi; l0 = csn_lo;
    do_xfer(wr, a2, size, trans, wdata, w, rd);
    if (exp_waits == 1 && !wr) exp_rdata = exp_last;
    checks = checks + 1;
    if (w != exp_waits) begin
      failures = failures + 1;
      $display("FAIL %s_waits: got %0d required %0d", name, w, exp_waits);
    end
    checks = checks + 1;
    if (rd !== exp_rdata) begin
      failures = failures + 1;
      $display("FAIL %s_data: got %h required %h", name, rd, exp_rdata);
    end
    checks = checks + 1;
    if (cnvst_hi != c0 || csn_lo != l0) begin
      failures = failures + 1;
      $display("FAIL %s_pins: cnvst=%0d csn_lo=%0d required 0/0", name, cnvst_hi - c0, csn_lo - l0);
    end
  endtask

  task automatic test_convert_read();
    convert_and_check("convert_a5a5", 32'hA5A5_3C3C);
  endtask

  task automatic test_read_last();
    short_xfer_check("read_last", 1'b0, 1'b1, 3'b010, 2'b10, 32'h0, 1);
  endtask

  task automatic test_write();
    short_xfer_check("write", 1'b1, 1'b0, 3'b010, 2'b10, 32'hFFFF_FFFF, 1);
    short_xfer_check("read_after_write", 1'b0, 1'b1, 3'b010, 2'b10, 32'h0, 1);
  endtask

  task automatic test_ignored();
    short_xfer_check("byte_read", 1'b0, 1'b0, 3'b000, 2'b10, 32'h0, 0);
    short_xfer_check("idle_trans", 1'b0, 1'b0, 3'b010, 2'b00, 32'h0, 0);
  endtask

  task automatic test_reset_mid_frame();
    int r0, n;
    adc_frame = $urandom;
    r0 = sclk_rise;
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = 32'h0;
    bus.HSIZE = 3'b010; bus.HTRANS = 2'b10;
    @(posedge clk);
    #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    n = 0;
    while (!(sclk_rise - r0 == 10 && sclk === 1'b0) && n < 1000) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    checks = checks + 1;
    if (n >= 1000) begin
      failures = failures + 1;
      $display("FAIL midreset_reach_bit10: rises=%0d required 10 within 1000 cycles", sclk_rise - r0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks = checks + 1;
    if (csn !== 1'b1 || sclk !== 1'b0 || cnvst !== 1'b0 ||
        bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0) begin
      failures = failures + 1;
      $display("FAIL midreset_state: csn=%b sclk=%b cnvst=%b hreadyout=%b hrdata=%h required 1/0/0/1/00000000",
               csn, sclk, cnvst, bus.HREADYOUT, bus.HRDATA);
    end
    rst = 1'b0;
    exp_last  = 32'h0;
    exp_rdata = 32'h0;
    short_xfer_check("midreset_last_cleared", 1'b0, 1'b1, 3'b010, 2'b10, 32'h0, 1);
    convert_and_check("midreset_fresh", 32'h1234_5678);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: convert_and_check("rand_convert", $urandom);
        1: short_xfer_check("rand_last", 1'b0, 1'b1, 3'b010, 2'b10, 32'h0, 1);
        2: short_xfer_check("rand_write", 1'b1, 1'($urandom_range(0, 1)), 3'b010, 2'b11, $urandom, 1);
        default: begin
          if ($urandom_range(0, 1) == 0)
            short_xfer_check("rand_badsize", 1'b0, 1'b0, 3'($urandom_range(0, 1)), 2'b10, 32'h0, 0);
          else
            short_xfer_check("rand_notrans", 1'b0, 1'b0, 3'b010, 2'($urandom_range(0, 1)), 32'h0, 0);
        end
      endcase
    end
    convert_and_check("rand_final_convert", $urandom);
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HADDR = 32'h0; bus.HWDATA = 32'h0;
    bus.HTRANS = 2'b00; bus.HSIZE = 3'b010; bus.HPROT = 4'h0; bus.HBURST = 3'b000;
    bus.HMASTLOCK = 1'b0;
    test_reset();
    test_convert_read();
    test_read_last();
    test_write();
    test_ignored();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
